column_drop_engine: RTL and testbench

Parametrised successor to the Connect4 column selector. It accepts a column request from the current player through a req/done handshake and keeps per-column fill heights. It drops the piece into the lowest free row and maintains occupancy and ownership bitmaps. It adds a bounded undo history, board-full detection, a synchronous clear and an error state that holds until a re-throw.

---
 rtl/connect4_pkg.sv | 22 ++
 rtl/move_history_stack.sv | 58 +++++
 rtl/column_drop_engine.sv | 193 +++++++++++++++++++
 tb/tb_column_drop_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared encodings, FSM states and board geometry for the column drop engine.
package connect4_pkg;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PLACE = 3'd2,
    ST_UNDO  = 3'd3,
    ST_ERROR = 3'd4
  } fsm_state_t;

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/move_history_stack.sv
// Circular LIFO of recent column numbers; a push when full overwrites the oldest entry.
module move_history_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] next_ptr_s;
  logic [PTR_W-1:0] top_ptr_s;
  logic [CNT_W-1:0] count_r;

  // Wrap-around neighbours of the write pointer and the current top entry.
  always_comb begin
    next_ptr_s = (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
    top_ptr_s  = (wr_ptr_r == {PTR_W{1'b0}}) ? LAST_PTR : wr_ptr_r - PTR_W'(1);
    top_data   = mem_r[top_ptr_s];
    empty      = (count_r == {CNT_W{1'b0}});
  end

  assign count = count_r;

  // Storage, pointer and saturating entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= next_ptr_s;
      if (count_r != FULL_CNT) count_r <= count_r + CNT_W'(1);
    end else if (pop && (count_r != {CNT_W{1'b0}})) begin
      wr_ptr_r <= top_ptr_s;
      count_r  <= count_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/column_drop_engine.sv
// Connect-style column drop engine: request handshake, per-column heights,
// occupancy/owner bitmaps, bounded undo, board-full detection and clear.
module column_drop_engine
  import connect4_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int COL_W      = 3,
  parameter int HIST_DEPTH = 8,
  localparam int CELLS  = ROWS * COLS,
  localparam int ROW_W  = $clog2(ROWS),
  localparam int CELL_W = $clog2(CELLS),
  localparam int CNT_W  = $clog2(CELLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic [COL_W-1:0]  in_column,
  input  logic              drop_req,
  input  logic              throw_again,
  input  logic              undo_req,
  input  logic              clear,
  output logic [CELLS-1:0]  out_gameboard,
  output logic [CELLS-1:0]  out_players_cells,
  output logic              invalid_column,
  output logic              busy,
  output logic              drop_done,
  output logic [ROW_W-1:0]  landed_row,
  output logic [CELL_W-1:0] landed_cell,
  output logic              undo_done,
  output logic [CNT_W-1:0]  move_count,
  output logic              board_full
);

  localparam int HCNT_W = $clog2(HIST_DEPTH + 1);
  localparam logic [ROW_W:0]   FULL_H    = ROWS[ROW_W:0];
  localparam logic [CNT_W-1:0] CELLS_CNT = CELLS[CNT_W-1:0];

  fsm_state_t        state_r, next_state_s;
  logic [COL_W-1:0]  col_r;
  logic [1:0]        player_r;
  logic [ROW_W:0]    height_r [COLS];
  logic [CELLS-1:0]  board_r, owner_r;
  logic [ROW_W-1:0]  landed_row_r;
  logic [CELL_W-1:0] landed_cell_r;
  logic [CNT_W-1:0]  move_count_r;
  logic              board_full_r, drop_done_r, undo_done_r, busy_r, invalid_r;

  logic [ROW_W:0]    col_height_s, pop_height_s, undo_height_s;
  logic [CELL_W-1:0] place_cell_s, undo_cell_s;
  logic [COL_W-1:0]  pop_col_s;
  logic              hist_empty_s, undo_ok_s, column_bad_s;
  logic [HCNT_W-1:0] hist_count_s;
  logic              latch_en_s, place_en_s, undo_en_s;

  move_history_stack #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (COL_W)
  ) u_history (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (clear),
    .push      (place_en_s),
    .pop       (undo_en_s),
    .push_data (col_r),
    .top_data  (pop_col_s),
    .empty     (hist_empty_s),
    .count     (hist_count_s)
  );

  // Heights of the requested column and of the column on top of the history.
  always_comb begin
    col_height_s = {(ROW_W+1){1'b0}};
    pop_height_s = {(ROW_W+1){1'b0}};
    for (int c = 0; c < COLS; c++) begin
      col_height_s = (int'(col_r) == c) ? height_r[c] : col_height_s;
      pop_height_s = (int'(pop_col_s) == c) ? height_r[c] : pop_height_s;
    end
    undo_height_s = pop_height_s - {{ROW_W{1'b0}}, 1'b1};
    place_cell_s  = CELL_W'(cell_idx(int'(col_height_s), int'(col_r), COLS));
    undo_cell_s   = CELL_W'(cell_idx(int'(undo_height_s), int'(pop_col_s), COLS));
    undo_ok_s     = !hist_empty_s && (hist_count_s != {HCNT_W{1'b0}});
    column_bad_s  = (int'(col_r) >= COLS) || (col_height_s == FULL_H) ||
                    !((player_r == P1) || (player_r == P2)) || board_full_r;
  end

  // FSM state register with registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy_r    <= (next_state_s == ST_CHECK) || (next_state_s == ST_PLACE) ||
                   (next_state_s == ST_UNDO);
      invalid_r <= (next_state_s == ST_ERROR);
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (drop_req)      next_state_s = ST_CHECK;
        else if (undo_req) next_state_s = ST_UNDO;
        else               next_state_s = ST_IDLE;
      end
      ST_CHECK: next_state_s = column_bad_s ? ST_ERROR : ST_PLACE;
      ST_PLACE: next_state_s = ST_IDLE;
      ST_UNDO:  next_state_s = ST_IDLE;
      ST_ERROR: next_state_s = throw_again ? ST_IDLE : ST_ERROR;
      default:  next_state_s = ST_IDLE;
    endcase
    if (clear) next_state_s = ST_IDLE;
    else       next_state_s = next_state_s;
  end

  // Datapath enables decoded from the current state.
  always_comb begin
    latch_en_s = 1'b0;
    place_en_s = 1'b0;
    undo_en_s  = 1'b0;
    case (state_r)
      ST_IDLE:  latch_en_s = drop_req && !clear;
      ST_PLACE: place_en_s = !clear;
      ST_UNDO:  undo_en_s  = undo_ok_s && !clear;
      default:  latch_en_s = 1'b0;
    endcase
  end

  // Board bitmaps, heights, counters and handshake pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r         <= {COL_W{1'b0}};
      player_r      <= 2'b00;
      board_r       <= {CELLS{1'b0}};
      owner_r       <= {CELLS{1'b0}};
      landed_row_r  <= {ROW_W{1'b0}};
      landed_cell_r <= {CELL_W{1'b0}};
      move_count_r  <= {CNT_W{1'b0}};
      board_full_r  <= 1'b0;
      drop_done_r   <= 1'b0;
      undo_done_r   <= 1'b0;
      for (int c = 0; c < COLS; c++) height_r[c] <= {(ROW_W+1){1'b0}};
    end else if (clear) begin
      board_r      <= {CELLS{1'b0}};
      owner_r      <= {CELLS{1'b0}};
      move_count_r <= {CNT_W{1'b0}};
      board_full_r <= 1'b0;
      drop_done_r  <= 1'b0;
      undo_done_r  <= 1'b0;
      for (int c = 0; c < COLS; c++) height_r[c] <= {(ROW_W+1){1'b0}};
    end else begin
      drop_done_r <= place_en_s;
      undo_done_r <= undo_en_s;
      if (latch_en_s) begin
        col_r    <= in_column;
        player_r <= state;
      end
      if (place_en_s) begin
        board_r[place_cell_s] <= 1'b1;
        owner_r[place_cell_s] <= (player_r == P2);
        landed_row_r          <= col_height_s[ROW_W-1:0];
        landed_cell_r         <= place_cell_s;
        move_count_r          <= move_count_r + CNT_W'(1);
        board_full_r          <= ((move_count_r + CNT_W'(1)) == CELLS_CNT);
        for (int c = 0; c < COLS; c++)
          if (int'(col_r) == c) height_r[c] <= col_height_s + {{ROW_W{1'b0}}, 1'b1};
      end else if (undo_en_s) begin
        board_r[undo_cell_s] <= 1'b0;
        owner_r[undo_cell_s] <= 1'b0;
        move_count_r         <= move_count_r - CNT_W'(1);
        board_full_r         <= 1'b0;
        for (int c = 0; c < COLS; c++)
          if (int'(pop_col_s) == c) height_r[c] <= undo_height_s;
      end
    end
  end

  assign out_gameboard     = board_r;
  assign out_players_cells = owner_r;
  assign invalid_column    = invalid_r;
  assign busy              = busy_r;
  assign drop_done         = drop_done_r;
  assign landed_row        = landed_row_r;
  assign landed_cell       = landed_cell_r;
  assign undo_done         = undo_done_r;
  assign move_count        = move_count_r;
  assign board_full        = board_full_r;

endmodule

// File: tb/tb_column_drop_engine.sv
// Directed bench for column_drop_engine with default geometry (6x7, history depth 8).
module tb_column_drop_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  player;
  logic [2:0]  in_column;
  logic        drop_req, throw_again, undo_req, clear;
  logic [41:0] out_gameboard, out_players_cells;
  logic        invalid_column, busy, drop_done, undo_done, board_full;
  logic [2:0]  landed_row;
  logic [5:0]  landed_cell;
  logic [5:0]  move_count;

  int vectors = 0;
  int miscompares = 0;

  column_drop_engine dut (
    .clk               (clk),
    .reset             (reset),
    .state             (player),
    .in_column         (in_column),
    .drop_req          (drop_req),
    .throw_again       (throw_again),
    .undo_req          (undo_req),
    .clear             (clear),
    .out_gameboard     (out_gameboard),
    .out_players_cells (out_players_cells),
    .invalid_column    (invalid_column),
    .busy              (busy),
    .drop_done         (drop_done),
    .landed_row        (landed_row),
    .landed_cell       (landed_cell),
    .undo_done         (undo_done),
    .move_count        (move_count),
    .board_full        (board_full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_drop(input logic [1:0] p, input logic [2:0] c,
                         output int lat, output bit done, output bit err);
    @(negedge clk);
    player = p; in_column = c; drop_req = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
    lat = 1; done = 1'b0; err = 1'b0;
    while (lat < 10 && !done && !err) begin
      if (drop_done === 1'b1) done = 1'b1;
      else if (invalid_column === 1'b1) err = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic do_undo(output bit pulsed);
    @(negedge clk); undo_req = 1'b1;
    @(negedge clk); undo_req = 1'b0;
    @(negedge clk); pulsed = undo_done;
  endtask

  task automatic do_throw();
    @(negedge clk); throw_again = 1'b1;
    @(negedge clk); throw_again = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; player = 2'b00; in_column = 3'd0;
    drop_req = 1'b0; throw_again = 1'b0; undo_req = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_gameboard, out_players_cells} !== 84'd0) begin
      miscompares++; $display("FAIL reset_bitmaps got=%h exp=0", {out_gameboard, out_players_cells});
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({invalid_column, busy, drop_done, undo_done, board_full} !== 5'b00000) begin
      miscompares++; $display("FAIL reset_flags got=%b exp=00000", {invalid_column, busy, drop_done, undo_done, board_full});
    end
    vectors++;
    if ({move_count, landed_row, landed_cell} !== 15'd0) begin
      miscompares++; $display("FAIL reset_counters got=%h exp=0", {move_count, landed_row, landed_cell});
    end
  endtask

  task automatic test_two_drops();
    int lat; bit done, err;
    do_drop(2'b01, 3'd0, lat, done, err);
    vectors++;
    if (!done || lat != 3 || landed_row !== 3'd0 || landed_cell !== 6'd0) begin
      miscompares++; $display("FAIL drop1 done=%0d lat=%0d row=%0d cell=%0d exp done=1 lat=3 row=0 cell=0", done, lat, landed_row, landed_cell);
    end
    do_drop(2'b10, 3'd0, lat, done, err);
    vectors++;
    if (!done || lat != 3 || landed_row !== 3'd1 || landed_cell !== 6'd7) begin
      miscompares++; $display("FAIL drop2 done=%0d lat=%0d row=%0d cell=%0d exp done=1 lat=3 row=1 cell=7", done, lat, landed_row, landed_cell);
    end
    vectors++;
    if (out_gameboard !== 42'h81 || out_players_cells !== 42'h80 || move_count !== 6'd2) begin
      miscompares++; $display("FAIL two_drops_board got=%h/%h/%0d exp=81/80/2", out_gameboard, out_players_cells, move_count);
    end
  endtask

  task automatic test_undo();
    bit p;
    do_undo(p);
    vectors++;
    if (!p || out_gameboard !== 42'h1 || out_players_cells !== 42'h0 || move_count !== 6'd1) begin
      miscompares++; $display("FAIL undo1 pulse=%0d board=%h own=%h cnt=%0d exp 1/1/0/1", p, out_gameboard, out_players_cells, move_count);
    end
    do_undo(p);
    vectors++;
    if (!p || out_gameboard !== 42'h0 || move_count !== 6'd0) begin
      miscompares++; $display("FAIL undo2 pulse=%0d board=%h cnt=%0d exp 1/0/0", p, out_gameboard, move_count);
    end
    do_undo(p);
    vectors++;
    if (p || out_gameboard !== 42'h0 || move_count !== 6'd0) begin
      miscompares++; $display("FAIL undo_empty pulse=%0d board=%h cnt=%0d exp 0/0/0", p, out_gameboard, move_count);
    end
  endtask

  task automatic test_clear_abort();
    int lat; bit done, err; bit seen;
    for (int stage = 1; stage <= 2; stage++) begin
      @(negedge clk);
      player = 2'b01; in_column = 3'd4; drop_req = 1'b1;
      @(negedge clk);
      drop_req = 1'b0;
      if (stage == 2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      seen = drop_done;
      repeat (3) begin
        @(negedge clk);
        seen = seen | drop_done;
      end
      vectors++;
      if (seen || out_gameboard !== 42'h0 || move_count !== 6'd0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL clear_abort_stage%0d done=%0d board=%h cnt=%0d busy=%0d exp 0/0/0/0", stage, seen, out_gameboard, move_count, busy);
      end
    end
    do_drop(2'b01, 3'd7, lat, done, err);
    do_clear();
    vectors++;
    if (!err || invalid_column !== 1'b0) begin
      miscompares++; $display("FAIL clear_error err=%0d invalid=%0d exp 1/0", err, invalid_column);
    end
  endtask

  task automatic test_column_full();
    int lat; bit done, err;
    for (int i = 0; i < 6; i++) do_drop((i % 2 == 0) ? 2'b01 : 2'b10, 3'd0, lat, done, err);
    vectors++;
    if (out_gameboard !== 42'h810204081 || out_players_cells !== 42'h800200080 || move_count !== 6'd6) begin
      miscompares++; $display("FAIL col0_filled board=%h own=%h cnt=%0d exp 810204081/800200080/6", out_gameboard, out_players_cells, move_count);
    end
    do_drop(2'b01, 3'd0, lat, done, err);
    vectors++;
    if (!err || done || invalid_column !== 1'b1 || busy !== 1'b0 || out_gameboard !== 42'h810204081 || move_count !== 6'd6) begin
      miscompares++; $display("FAIL col_full_error err=%0d done=%0d inv=%0d busy=%0d board=%h cnt=%0d", err, done, invalid_column, busy, out_gameboard, move_count);
    end
    do_throw();
    vectors++;
    if (invalid_column !== 1'b0) begin
      miscompares++; $display("FAIL throw_again invalid=%0d exp=0", invalid_column);
    end
    do_drop(2'b01, 3'd1, lat, done, err);
    vectors++;
    if (!done || out_gameboard !== 42'h810204083 || landed_cell !== 6'd1 || move_count !== 6'd7) begin
      miscompares++; $display("FAIL drop_col1 done=%0d board=%h cell=%0d cnt=%0d exp 1/810204083/1/7", done, out_gameboard, landed_cell, move_count);
    end
  endtask

  task automatic test_invalid_inputs();
    int lat; bit done, err;
    logic [1:0] bad_player [2];
    bad_player[0] = 2'b00; bad_player[1] = 2'b11;
    do_drop(2'b01, 3'd7, lat, done, err);
    vectors++;
    if (!err || invalid_column !== 1'b1 || move_count !== 6'd7) begin
      miscompares++; $display("FAIL col7_error err=%0d inv=%0d cnt=%0d exp 1/1/7", err, invalid_column, move_count);
    end
    // throw_again together with a drop request: the drop must be dropped.
    @(negedge clk); throw_again = 1'b1; drop_req = 1'b1; player = 2'b01; in_column = 3'd5;
    @(negedge clk); throw_again = 1'b0; drop_req = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (invalid_column !== 1'b0 || move_count !== 6'd7 || out_gameboard !== 42'h810204083) begin
      miscompares++; $display("FAIL throw_with_drop inv=%0d cnt=%0d board=%h exp 0/7/810204083", invalid_column, move_count, out_gameboard);
    end
    for (int i = 0; i < 2; i++) begin
      do_drop(bad_player[i], 3'd2, lat, done, err);
      vectors++;
      if (!err || done || move_count !== 6'd7) begin
        miscompares++; $display("FAIL bad_player_%b err=%0d done=%0d cnt=%0d exp 1/0/7", bad_player[i], err, done, move_count);
      end
      do_throw();
    end
    // Requests arriving while busy are ignored.
    @(negedge clk); player = 2'b10; in_column = 3'd2; drop_req = 1'b1;
    @(negedge clk); in_column = 3'd3;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL busy_check busy=%0d exp=1", busy);
    end
    @(negedge clk); drop_req = 1'b0; undo_req = 1'b1;
    @(negedge clk); undo_req = 1'b0;
    vectors++;
    if (drop_done !== 1'b1 || landed_cell !== 6'd2) begin
      miscompares++; $display("FAIL busy_drop done=%0d cell=%0d exp 1/2", drop_done, landed_cell);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (move_count !== 6'd8 || out_gameboard !== 42'h810204087 || out_players_cells !== 42'h800200084 || busy !== 1'b0 || undo_done !== 1'b0) begin
      miscompares++; $display("FAIL busy_ignored cnt=%0d board=%h own=%h busy=%0d undo=%0d exp 8/810204087/800200084/0/0", move_count, out_gameboard, out_players_cells, busy, undo_done);
    end
  endtask

  task automatic test_full_board_and_history();
    int lat; bit done, err, p;
    int pulses;
    logic [41:0] exp_board, exp_own;
    do_clear();
    exp_board = '0; exp_own = '0;
    for (int k = 0; k < 42; k++) begin
      do_drop((k % 2 == 0) ? 2'b01 : 2'b10, 3'(k / 6), lat, done, err);
      exp_board[(k % 6) * 7 + k / 6] = 1'b1;
      exp_own[(k % 6) * 7 + k / 6]   = (k % 2 == 1);
    end
    vectors++;
    if (out_gameboard !== exp_board || out_players_cells !== exp_own || move_count !== 6'd42 || board_full !== 1'b1) begin
      miscompares++; $display("FAIL board_full board=%h own=%h cnt=%0d full=%0d exp %h/%h/42/1", out_gameboard, out_players_cells, move_count, board_full, exp_board, exp_own);
    end
    do_drop(2'b01, 3'd3, lat, done, err);
    vectors++;
    if (!err || done || move_count !== 6'd42) begin
      miscompares++; $display("FAIL full_drop err=%0d done=%0d cnt=%0d exp 1/0/42", err, done, move_count);
    end
    do_throw();
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      do_undo(p);
      if (p) pulses++;
    end
    for (int k = 34; k < 42; k++) begin
      exp_board[(k % 6) * 7 + k / 6] = 1'b0;
      exp_own[(k % 6) * 7 + k / 6]   = 1'b0;
    end
    vectors++;
    if (pulses != 8 || move_count !== 6'd34 || board_full !== 1'b0 || out_gameboard !== exp_board || out_players_cells !== exp_own) begin
      miscompares++; $display("FAIL nine_undos pulses=%0d cnt=%0d full=%0d board=%h exp 8/34/0/%h", pulses, move_count, board_full, out_gameboard, exp_board);
    end
    do_drop(2'b01, 3'd6, lat, done, err);
    vectors++;
    if (!done || landed_row !== 3'd0 || landed_cell !== 6'd6 || move_count !== 6'd35) begin
      miscompares++; $display("FAIL regrow_col6 done=%0d row=%0d cell=%0d cnt=%0d exp 1/0/6/35", done, landed_row, landed_cell, move_count);
    end
    do_clear();
    vectors++;
    if (out_gameboard !== 42'h0 || out_players_cells !== 42'h0 || move_count !== 6'd0 || board_full !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL clear_all board=%h own=%h cnt=%0d full=%0d busy=%0d exp all 0", out_gameboard, out_players_cells, move_count, board_full, busy);
    end
    do_undo(p);
    vectors++;
    if (p || move_count !== 6'd0) begin
      miscompares++; $display("FAIL undo_after_clear pulse=%0d cnt=%0d exp 0/0", p, move_count);
    end
  endtask

  initial begin
    test_reset();
    test_two_drops();
    test_undo();
    test_clear_abort();
    test_column_full();
    test_invalid_inputs();
    test_full_board_and_history();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
